i2c_reg_bank: RTL and testbench
===============================

Name: i2c_reg_bank

Overview:
Register-bank target for the I2C slave core's register interface. It consumes single-cycle reg_request strobes and answers with reg_response and reg_read_data. It exposes ID, scratch, control and status registers, plus two byte-stream FIFOs: TX carries I2C host to fabric, RX carries fabric to I2C host. A NACK is signalled by withholding reg_response on a write.

Parameters:
ADDR_WIDTH, 8, register address width; must match the slave core.
FIFO_DEPTH, 16, entries per FIFO; a power of 2, 2..128.
ID_VALUE, 8'hA5, value returned at address 0x00.
VERSION, 8'h01, value returned at address 0x01.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
reg_address  in  ADDR_WIDTH  register address; valid with reg_request
reg_is_write  in  1  1 = write, 0 = read; valid with reg_request
reg_request  in  1  single-cycle request strobe
reg_write_data  in  8  write data; valid with reg_request
reg_response  out  1  single-cycle acknowledge
reg_read_data  out  8  read data; valid while reg_response=1
tx_data  out  8  TX FIFO head
tx_valid  out  1  TX FIFO not empty
tx_ready  in  1  downstream pops TX when tx_valid&tx_ready
rx_data  in  8  byte from fabric
rx_valid  in  1  fabric offers a byte
rx_ready  out  1  RX FIFO not full; push when rx_valid&rx_ready
ctrl_gpo  out  3  CTRL[7:5]
irq  out  1  registered interrupt

Behaviour:
- Reset (synchronous, active-high; clock clock) clears:
  - reg_response=0, reg_read_data=0, irq=0;
  - both FIFOs empty, so tx_valid=0 and rx_ready=1;
  - CTRL=0, SCRATCH=0, sticky bits=0.
- Reset mid-transaction drops any pending response.
- Latency: a request at cycle N is decoded using state as of cycle N. reg_response and reg_read_data are registered and appear at N+1.
- Back-to-back requests on consecutive cycles are each served.
- Reads always respond.
- A write responds only if accepted. A rejected write gives no reg_response, which the slave core turns into a NACK.
- reg_read_data holds its last value when reg_response=0.
- Register map (byte wide):
  - 0x00 ID, RO.
  - 0x01 VERSION, RO.
  - 0x02 SCRATCH, RW.
  - 0x03 CTRL, RW:
    - [0] irq_en_tx_ovf; [1] irq_en_rx_udf; [2] irq_en_rx_avail;
    - [3] tx_flush and [4] rx_flush: self-clearing, read as 0, empty that FIFO on the cycle after the write;
    - [7:5] ctrl_gpo.
  - 0x04 STATUS, RO: {2'b0, rx_udf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full}.
  - 0x05 STICKY: read returns {6'b0, rx_udf, tx_ovf}; write-1-to-clear; always accepted.
  - 0x06 TX_LEVEL, RO: TX occupancy, 0..FIFO_DEPTH.
  - 0x07 RX_LEVEL, RO: RX occupancy, 0..FIFO_DEPTH.
  - 0x08 TX_DATA, WO:
    - write pushes reg_write_data;
    - if TX is full at cycle N: no push, no response, tx_ovf set;
    - read returns 0x00, with no side effect.
  - 0x09 RX_DATA, RO:
    - read returns the head and pops it;
    - if RX is empty: returns 0x00 and sets rx_udf;
    - write is rejected.
- Unmapped addresses: read returns 0xFF; write is rejected.
- Writes to RO registers are rejected and leave the register unchanged.
- Simultaneous events:
  - a TX push and a tx_ready pop in the same cycle both occur; level is unchanged;
  - "full" is evaluated before that cycle's pop, so a write at full is rejected even if the fabric pops concurrently;
  - the same rules apply to an RX push with a pop via RX_DATA read;
  - a flush has priority over a same-cycle push or pop;
  - a sticky set and a W1C in the same cycle: set wins.
- Level counters are $clog2(FIFO_DEPTH)+1 bits wide and zero-extended to 8 bits. Pointers wrap modulo FIFO_DEPTH.
- irq is registered: irq <= (tx_ovf&en0) | (rx_udf&en1) | (!rx_empty&en2).

Decomposition:
- Package i2c_reg_bank_pkg holds:
  - address constants ADDR_ID..ADDR_RX_DATA;
  - CTRL and STATUS bit indices;
  - READ_UNMAPPED = 8'hFF.
- One sub-module sync_fifo, parameterised by WIDTH and DEPTH, instantiated twice. It provides:
  - push, pop and flush inputs;
  - head data;
  - full, empty and level outputs.

Test Plan:
- Reset, then read 0x00, 0x01, 0x04 -> reg_response at N+1 each time, with data 0xA5, 0x01, 0x0A.
- Write 0x02=0x3C, then read 0x02 -> both respond; read returns 0x3C. Write 0x00=0x12 -> no response; read 0x00 still returns 0xA5.
- tx_ready=0; write 17 bytes to 0x08 -> first 16 respond, 17th gets no response; STICKY reads 0x01 and TX_LEVEL reads 0x10. Set tx_ready=1 -> tx_data streams the first 16 bytes in order.
- Drive rx 0x11, 0x22; read 0x09 three times -> returns 0x11, 0x22, 0x00; STICKY reads 0x02. Write 0x05=0x02 -> STICKY reads 0x00.
- Write CTRL=0x04; push one rx byte -> irq=1 two cycles after the push. Read 0x09 -> irq returns to 0.
- TX full with tx_ready=1 and a concurrent TX_DATA write -> write rejected and level drops to 15. Separately: write CTRL=0x08 -> TX empties and CTRL reads 0x00.

Source files
------------

// File: rtl/i2c_reg_bank_pkg.sv
// Shared constants for the I2C register bank: address map, CTRL/STATUS bit positions.
package i2c_reg_bank_pkg;

    localparam int unsigned ADDR_ID       = 'h00;
    localparam int unsigned ADDR_VERSION  = 'h01;
    localparam int unsigned ADDR_SCRATCH  = 'h02;
    localparam int unsigned ADDR_CTRL     = 'h03;
    localparam int unsigned ADDR_STATUS   = 'h04;
    localparam int unsigned ADDR_STICKY   = 'h05;
    localparam int unsigned ADDR_TX_LEVEL = 'h06;
    localparam int unsigned ADDR_RX_LEVEL = 'h07;
    localparam int unsigned ADDR_TX_DATA  = 'h08;
    localparam int unsigned ADDR_RX_DATA  = 'h09;

    localparam int unsigned CTRL_IRQ_EN_TX_OVF   = 0;
    localparam int unsigned CTRL_IRQ_EN_RX_UDF   = 1;
    localparam int unsigned CTRL_IRQ_EN_RX_AVAIL = 2;
    localparam int unsigned CTRL_TX_FLUSH        = 3;
    localparam int unsigned CTRL_RX_FLUSH        = 4;
    localparam int unsigned CTRL_GPO_LSB         = 5;

    // Flush bits are strobes and are never stored.
    localparam logic [7:0] CTRL_STORED_MASK = 8'hE7;

    localparam int unsigned STAT_TX_FULL  = 0;
    localparam int unsigned STAT_TX_EMPTY = 1;
    localparam int unsigned STAT_RX_FULL  = 2;
    localparam int unsigned STAT_RX_EMPTY = 3;
    localparam int unsigned STAT_TX_OVF   = 4;
    localparam int unsigned STAT_RX_UDF   = 5;

    localparam logic [7:0] READ_UNMAPPED = 8'hFF;

endpackage

// File: rtl/i2c_reg_bank_sync_fifo.sv
// Single-clock FIFO with occupancy count; flush overrides any same-cycle push or pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) begin
                count <= count + LW'(1);
            end else if (pop && !push) begin
                count <= count - LW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_reg_bank.sv
// Byte-wide register bank behind the I2C slave core, with TX (host->fabric) and
// RX (fabric->host) FIFOs. Rejected writes withhold reg_response to produce a NACK.
module i2c_reg_bank
    import i2c_reg_bank_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  ID_VALUE   = 8'hA5,
    parameter logic [7:0]  VERSION    = 8'h01
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] reg_address,
    input  logic                  reg_is_write,
    input  logic                  reg_request,
    input  logic [7:0]            reg_write_data,
    output logic                  reg_response,
    output logic [7:0]            reg_read_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [2:0]            ctrl_gpo,
    output logic                  irq
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_req, wr_req, wr_accept;
    logic          sel_scratch, sel_ctrl, sel_sticky, sel_tx_data, sel_rx_data;
    logic          tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [LW-1:0] tx_level, rx_level;
    logic [7:0]    rx_head, read_mux, scratch, ctrl;
    logic          tx_ovf, rx_udf, set_tx_ovf, set_rx_udf, sticky_w1c;

    assign rd_req = reg_request & ~reg_is_write;
    assign wr_req = reg_request & reg_is_write;

    assign sel_scratch = (reg_address == ADDR_WIDTH'(ADDR_SCRATCH));
    assign sel_ctrl    = (reg_address == ADDR_WIDTH'(ADDR_CTRL));
    assign sel_sticky  = (reg_address == ADDR_WIDTH'(ADDR_STICKY));
    assign sel_tx_data = (reg_address == ADDR_WIDTH'(ADDR_TX_DATA));
    assign sel_rx_data = (reg_address == ADDR_WIDTH'(ADDR_RX_DATA));

    // Full/empty are pre-pop values, so a concurrent pop never rescues a write at full.
    assign tx_push    = wr_req & sel_tx_data & ~tx_full;
    assign tx_pop     = tx_valid & tx_ready;
    assign tx_flush   = wr_req & sel_ctrl & reg_write_data[CTRL_TX_FLUSH];
    assign rx_push    = rx_valid & rx_ready;
    assign rx_pop     = rd_req & sel_rx_data & ~rx_empty;
    assign rx_flush   = wr_req & sel_ctrl & reg_write_data[CTRL_RX_FLUSH];
    assign set_tx_ovf = wr_req & sel_tx_data & tx_full;
    assign set_rx_udf = rd_req & sel_rx_data & rx_empty;
    assign sticky_w1c = wr_req & sel_sticky;
    assign wr_accept  = wr_req & (sel_scratch | sel_ctrl | sel_sticky | tx_push);

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;
    assign ctrl_gpo = ctrl[7:CTRL_GPO_LSB];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .pop       (tx_pop),
        .flush     (tx_flush),
        .push_data (reg_write_data),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .pop       (rx_pop),
        .flush     (rx_flush),
        .push_data (rx_data),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    always_comb begin
        read_mux = READ_UNMAPPED;
        case (reg_address)
            ADDR_WIDTH'(ADDR_ID):       read_mux = ID_VALUE;
            ADDR_WIDTH'(ADDR_VERSION):  read_mux = VERSION;
            ADDR_WIDTH'(ADDR_SCRATCH):  read_mux = scratch;
            ADDR_WIDTH'(ADDR_CTRL):     read_mux = ctrl;
            ADDR_WIDTH'(ADDR_STATUS):   read_mux = {2'b00, rx_udf, tx_ovf,
                                                    rx_empty, rx_full, tx_empty, tx_full};
            ADDR_WIDTH'(ADDR_STICKY):   read_mux = {6'b0, rx_udf, tx_ovf};
            ADDR_WIDTH'(ADDR_TX_LEVEL): read_mux = 8'(tx_level);
            ADDR_WIDTH'(ADDR_RX_LEVEL): read_mux = 8'(rx_level);
            ADDR_WIDTH'(ADDR_TX_DATA):  read_mux = 8'h00;
            ADDR_WIDTH'(ADDR_RX_DATA):  read_mux = rx_empty ? 8'h00 : rx_head;
            default:                    read_mux = READ_UNMAPPED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reg_response  <= 1'b0;
            reg_read_data <= 8'h00;
            scratch       <= 8'h00;
            ctrl          <= 8'h00;
            tx_ovf        <= 1'b0;
            rx_udf        <= 1'b0;
            irq           <= 1'b0;
        end else begin
            reg_response <= rd_req | wr_accept;
            if (rd_req) reg_read_data <= read_mux;
            if (wr_req && sel_scratch) scratch <= reg_write_data;
            if (wr_req && sel_ctrl) ctrl <= reg_write_data & CTRL_STORED_MASK;
            // Set beats a same-cycle write-1-to-clear.
            tx_ovf <= set_tx_ovf | (tx_ovf & ~(sticky_w1c & reg_write_data[0]));
            rx_udf <= set_rx_udf | (rx_udf & ~(sticky_w1c & reg_write_data[1]));
            irq <= (tx_ovf & ctrl[CTRL_IRQ_EN_TX_OVF])
                 | (rx_udf & ctrl[CTRL_IRQ_EN_RX_UDF])
                 | (~rx_empty & ctrl[CTRL_IRQ_EN_RX_AVAIL]);
        end
    end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed self-checking bench for i2c_reg_bank with default parameters.
module tb_i2c_reg_bank;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] reg_address = 8'h00;
    logic       reg_is_write = 1'b0;
    logic       reg_request = 1'b0;
    logic [7:0] reg_write_data = 8'h00;
    logic       reg_response;
    logic [7:0] reg_read_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [2:0] ctrl_gpo;
    logic       irq;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    i2c_reg_bank dut (
        .clock          (clock),
        .reset          (reset),
        .reg_address    (reg_address),
        .reg_is_write   (reg_is_write),
        .reg_request    (reg_request),
        .reg_write_data (reg_write_data),
        .reg_response   (reg_response),
        .reg_read_data  (reg_read_data),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .ctrl_gpo       (ctrl_gpo),
        .irq            (irq)
    );

    // One request in cycle N; response/data sampled 1ns after the edge ending N.
    task automatic bus(input logic [7:0] addr, input logic wr, input logic [7:0] wdata,
                       output logic resp, output logic [7:0] rdata);
        @(negedge clock);
        reg_address = addr;
        reg_is_write = wr;
        reg_write_data = wdata;
        reg_request = 1'b1;
        @(posedge clock);
        #1;
        resp = reg_response;
        rdata = reg_read_data;
        reg_request = 1'b0;
    endtask

    task automatic test_reset();
        logic r;
        logic [7:0] d;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        // A request arriving while reset is asserted must not produce a response.
        bus(8'h00, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (r !== 1'b0 || d !== 8'h00 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: resp=%b data=%h irq=%b want 0/00/0", r, d, irq);
        end
        n_cmp++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || ctrl_gpo !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_fifo: tx_valid=%b rx_ready=%b gpo=%0d want 0/1/0",
                     tx_valid, rx_ready, ctrl_gpo);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_id_reads();
        logic [7:0] addrs [5] = '{8'h00, 8'h01, 8'h04, 8'h0F, 8'h08};
        logic [7:0] exps  [5] = '{8'hA5, 8'h01, 8'h0A, 8'hFF, 8'h00};
        logic r;
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            bus(addrs[i], 1'b0, 8'h00, r, d);
            n_cmp++;
            if (r !== 1'b1 || d !== exps[i]) begin
                n_fail++;
                $display("FAIL read_%h: resp=%b data=%h want 1/%h", addrs[i], r, d, exps[i]);
            end
        end
    endtask

    task automatic test_scratch();
        logic r;
        logic [7:0] d;
        bus(8'h02, 1'b1, 8'h3C, r, d);
        n_cmp++;
        if (r !== 1'b1) begin
            n_fail++;
            $display("FAIL scratch_wr: resp=%b want 1", r);
        end
        bus(8'h02, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (r !== 1'b1 || d !== 8'h3C) begin
            n_fail++;
            $display("FAIL scratch_rd: resp=%b data=%h want 1/3c", r, d);
        end
        bus(8'h00, 1'b1, 8'h12, r, d);
        n_cmp++;
        if (r !== 1'b0 || d !== 8'h3C) begin
            n_fail++;
            $display("FAIL ro_write: resp=%b data=%h want 0/3c (held)", r, d);
        end
        bus(8'h00, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (r !== 1'b1 || d !== 8'hA5) begin
            n_fail++;
            $display("FAIL id_after_wr: resp=%b data=%h want 1/a5", r, d);
        end
        bus(8'h20, 1'b1, 8'h55, r, d);
        n_cmp++;
        if (r !== 1'b0) begin
            n_fail++;
            $display("FAIL unmapped_wr: resp=%b want 0", r);
        end
    endtask

    task automatic test_tx_overflow();
        logic r;
        logic [7:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus(8'h08, 1'b1, 8'h40 + 8'(i), r, d);
            n_cmp++;
            if (r !== (i < 16)) begin
                n_fail++;
                $display("FAIL tx_push_%0d: resp=%b want %b", i, r, (i < 16));
            end
        end
        bus(8'h05, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (d !== 8'h01) begin
            n_fail++;
            $display("FAIL sticky_ovf: data=%h want 01", d);
        end
        bus(8'h06, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (d !== 8'h10) begin
            n_fail++;
            $display("FAIL tx_level_full: data=%h want 10", d);
        end
        bus(8'h04, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (d !== 8'h19) begin
            n_fail++;
            $display("FAIL status_full: data=%h want 19", d);
        end
        @(negedge clock);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h40 + 8'(i)) begin
                n_fail++;
                $display("FAIL tx_stream_%0d: valid=%b data=%h want 1/%h",
                         i, tx_valid, tx_data, 8'h40 + 8'(i));
            end
            @(negedge clock);
        end
        tx_ready = 1'b0;
        n_cmp++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_drained: valid=%b want 0", tx_valid);
        end
        bus(8'h05, 1'b1, 8'h01, r, d);
        bus(8'h05, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL sticky_clr_ovf: data=%h want 00", d);
        end
    endtask

    task automatic test_rx();
        logic [7:0] exps [3] = '{8'h11, 8'h22, 8'h00};
        logic r;
        logic [7:0] d;
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data = 8'h11;
        @(negedge clock);
        rx_data = 8'h22;
        @(negedge clock);
        rx_valid = 1'b0;
        bus(8'h07, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (d !== 8'h02) begin
            n_fail++;
            $display("FAIL rx_level: data=%h want 02", d);
        end
        for (int i = 0; i < 3; i++) begin
            bus(8'h09, 1'b0, 8'h00, r, d);
            n_cmp++;
            if (r !== 1'b1 || d !== exps[i]) begin
                n_fail++;
                $display("FAIL rx_pop_%0d: resp=%b data=%h want 1/%h", i, r, d, exps[i]);
            end
        end
        bus(8'h05, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (d !== 8'h02) begin
            n_fail++;
            $display("FAIL sticky_udf: data=%h want 02", d);
        end
        bus(8'h05, 1'b1, 8'h02, r, d);
        n_cmp++;
        if (r !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_w1c_resp: resp=%b want 1", r);
        end
        bus(8'h05, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL sticky_clr_udf: data=%h want 00", d);
        end
        bus(8'h09, 1'b1, 8'h33, r, d);
        n_cmp++;
        if (r !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_data_wr: resp=%b want 0", r);
        end
    endtask

    task automatic test_irq();
        logic r;
        logic [7:0] d;
        bus(8'h03, 1'b1, 8'hA4, r, d);
        bus(8'h03, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (d !== 8'hA4 || ctrl_gpo !== 3'd5) begin
            n_fail++;
            $display("FAIL ctrl_rd: data=%h gpo=%0d want a4/5", d, ctrl_gpo);
        end
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data = 8'h77;
        @(posedge clock);
        #1;
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_early: irq=%b want 0", irq);
        end
        @(negedge clock);
        rx_valid = 1'b0;
        @(posedge clock);
        #1;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_set: irq=%b want 1", irq);
        end
        bus(8'h09, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (d !== 8'h77) begin
            n_fail++;
            $display("FAIL irq_pop: data=%h want 77", d);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear: irq=%b want 0", irq);
        end
        bus(8'h03, 1'b1, 8'h00, r, d);
    endtask

    task automatic test_back_to_back();
        logic r;
        logic [7:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) bus(8'h08, 1'b1, 8'h80 + 8'(i), r, d);
        // Pop concurrent with a write at full: write still rejected.
        tx_ready = 1'b1;
        bus(8'h08, 1'b1, 8'hEE, r, d);
        tx_ready = 1'b0;
        n_cmp++;
        if (r !== 1'b0) begin
            n_fail++;
            $display("FAIL full_concurrent: resp=%b want 0", r);
        end
        bus(8'h06, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (d !== 8'h0F || tx_data !== 8'h81) begin
            n_fail++;
            $display("FAIL level_after_pop: level=%h head=%h want 0f/81", d, tx_data);
        end
        tx_ready = 1'b1;
        bus(8'h08, 1'b1, 8'hDD, r, d);
        tx_ready = 1'b0;
        bus(8'h06, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (r !== 1'b1 || d !== 8'h0F) begin
            n_fail++;
            $display("FAIL push_pop_same: resp=%b level=%h want 1/0f", r, d);
        end
        bus(8'h03, 1'b1, 8'h08, r, d);
        n_cmp++;
        if (r !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_resp: resp=%b want 1", r);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty: tx_valid=%b want 0", tx_valid);
        end
        bus(8'h06, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL flush_level: data=%h want 00", d);
        end
        bus(8'h03, 1'b0, 8'h00, r, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL flush_selfclr: data=%h want 00", d);
        end
    endtask

    initial begin
        test_reset();
        test_id_reads();
        test_scratch();
        test_tx_overflow();
        test_rx();
        test_irq();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
